// File: rtl/trigger_pkg.sv
// Shared types and constants for the edge trigger detector.
//   trig_state_t : detector FSM states
//   SLOPE_RISE / SLOPE_FALL : encodings of the slope select input
package trigger_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned HOLD_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMING  = 2'd1,
        READY   = 2'd2,
        HOLDOFF = 2'd3
    } trig_state_t;

    localparam logic SLOPE_RISE = 1'b0;
    localparam logic SLOPE_FALL = 1'b1;

endpackage

// File: rtl/trig_holdoff_timer.sv
// Holdoff dead-time counter. Loaded with the holdoff length when a trigger
// fires, then counts down one per clk and parks at zero.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val this cycle (takes priority over counting)
//   load_val   : holdoff length in clk cycles
//   done_c     : combinational, high during the last holdoff cycle (count==1)
module trig_holdoff_timer
    import trigger_pkg::*;
#(
    parameter int unsigned HOLD_W = HOLD_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [HOLD_W-1:0] load_val,
    output logic              done_c
);

    logic [HOLD_W-1:0] count;

    // Down-counter; holds at zero so it never wraps while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - HOLD_W'(1);
        end
    end

    assign done_c = (count == HOLD_W'(1));

endmodule

// File: rtl/trigger_detect.sv
// Edge trigger detector: emits a 1-cycle trig_enable pulse when the sample
// stream crosses level on the selected slope, after first leaving the
// hysteresis band on the far side. A holdoff window follows each trigger.
//   clk, rst_n   : clock, asynchronous active-low reset
//   arm          : 1 = detector enabled, 0 = forced IDLE
//   slope        : 0 = rising, 1 = falling
//   level, hyst  : trigger threshold and hysteresis half-band (unsigned)
//   holdoff      : dead time after a trigger, in clk cycles
//   sample_valid : qualifies sample
//   sample       : ADC sample, unsigned
//   trig_enable  : registered 1-cycle trigger pulse
//   ready        : registered, high while waiting for a crossing
module trigger_detect
    import trigger_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned HOLD_W = HOLD_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              arm,
    input  logic              slope,
    input  logic [DATA_W-1:0] level,
    input  logic [DATA_W-1:0] hyst,
    input  logic [HOLD_W-1:0] holdoff,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample,
    output logic              trig_enable,
    output logic              ready
);

    trig_state_t       state;
    trig_state_t       state_d;
    logic              slope_q;
    logic              fire_c;
    logic              load_c;
    logic              done_c;
    logic [DATA_W:0]   lo_diff_c;
    logic [DATA_W:0]   hi_sum_c;
    logic [DATA_W-1:0] lo_th_c;
    logic [DATA_W-1:0] hi_th_c;
    logic              out_band_c;
    logic              cross_c;
    logic              slope_chg_c;

    // Band edges computed one bit wider, then clamped to the code range.
    assign lo_diff_c = {1'b0, level} - {1'b0, hyst};
    assign hi_sum_c  = {1'b0, level} + {1'b0, hyst};
    assign lo_th_c   = lo_diff_c[DATA_W] ? '0 : lo_diff_c[DATA_W-1:0];
    assign hi_th_c   = hi_sum_c[DATA_W]  ? '1 : hi_sum_c[DATA_W-1:0];

    // Arming needs a sample strictly beyond the band on the far side.
    assign out_band_c  = (slope == SLOPE_RISE) ? (sample < lo_th_c) : (sample > hi_th_c);
    assign cross_c     = (slope == SLOPE_RISE) ? (sample >= level) : (sample <= level);
    assign slope_chg_c = (slope != slope_q);

    // Next-state and fire decision; arm=0 overrides everything.
    always_comb begin
        state_d = state;
        fire_c  = 1'b0;
        load_c  = 1'b0;
        if (!arm) begin
            state_d = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    state_d = ARMING;
                end
                ARMING: begin
                    if (!slope_chg_c && sample_valid && out_band_c) begin
                        state_d = READY;
                    end
                end
                READY: begin
                    if (slope_chg_c) begin
                        state_d = ARMING;
                    end else if (sample_valid && cross_c) begin
                        fire_c = 1'b1;
                        if (holdoff == '0) begin
                            state_d = ARMING;
                        end else begin
                            load_c  = 1'b1;
                            state_d = HOLDOFF;
                        end
                    end
                end
                HOLDOFF: begin
                    if (slope_chg_c || done_c) begin
                        state_d = ARMING;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            trig_enable <= 1'b0;
            ready       <= 1'b0;
            slope_q     <= SLOPE_RISE;
        end else begin
            state       <= state_d;
            trig_enable <= fire_c;
            ready       <= (state_d == READY);
            slope_q     <= slope;
        end
    end

    trig_holdoff_timer #(
        .HOLD_W (HOLD_W)
    ) u_holdoff (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load_c),
        .load_val (holdoff),
        .done_c   (done_c)
    );

endmodule
